// File: rtl/clt_gaussian_acc.sv
// Central Limit Theorem noise source: sums N uniform samples into a centered signed sample.
// Optional CLT_DROP_COUNT_EN adds a saturating count of samples discarded while a result waits.
module clt_gaussian_acc #(
  parameter int UW     = 16,
  parameter int LOG2_N = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    urgn_seed,
  input  logic                           urgn_valid,
  output logic signed [UW+LOG2_N-1:0]    noise_out,
  output logic                           noise_valid,
  input  logic                           noise_ready
`ifdef CLT_DROP_COUNT_EN
  ,
  output logic [15:0]                    drop_count
`endif
);

  localparam int OW = UW + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  // Inverting the MSB subtracts N*2**(UW-1), the mean of the unsigned sum.
  function automatic logic signed [OW-1:0] center(input logic [OW-1:0] s);
    return {~s[OW-1], s[OW-2:0]};
  endfunction

  state_t                   state, state_n;
  logic [OW-1:0]            acc, acc_n;
  logic [LOG2_N-1:0]        cnt, cnt_n;
  logic signed [OW-1:0]     out_n;
  logic                     vld_n;
  logic                     drop;
  logic                     out_free;
  logic [OW-1:0]            u_p0;
  logic [OW-1:0]            sum_p0;
  logic                     unused_seed;

  assign unused_seed = ^urgn_seed;
  assign u_p0        = {{LOG2_N{1'b0}}, urgn_seed[31:32-UW]};
  assign sum_p0      = acc + u_p0;
  assign out_free    = !noise_valid || noise_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = noise_out;
    vld_n   = noise_valid && !noise_ready;
    drop    = 1'b0;
    case (state)
      ST_ACC: begin
        if (urgn_valid) begin
          if (cnt != CNT_LAST) begin
            acc_n = (cnt == '0) ? u_p0 : sum_p0;
            cnt_n = cnt + LOG2_N'(1);
          end else begin
            cnt_n = '0;
            if (out_free) begin
              out_n = center(sum_p0);
              vld_n = 1'b1;
            end else begin
              acc_n   = sum_p0;
              state_n = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        drop = urgn_valid;
        if (out_free) begin
          out_n   = center(acc);
          vld_n   = 1'b1;
          cnt_n   = '0;
          state_n = ST_ACC;
        end
      end
      default: state_n = ST_ACC;
    endcase
  end

  // Stage p0 -> registered state and output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_ACC;
      acc         <= '0;
      cnt         <= '0;
      noise_out   <= '0;
      noise_valid <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      noise_out   <= out_n;
      noise_valid <= vld_n;
    end
  end

`ifdef CLT_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_clt_gaussian_acc.sv
// Directed bench for clt_gaussian_acc: table of 4-sample vectors plus multi-cycle corner sequences.
module tb_clt_gaussian_acc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] urgn_seed;
  logic        urgn_valid;
  logic [9:0]  noise_out;
  logic        noise_valid;
  logic        noise_ready;
  logic [31:0] seed2;
  logic        valid2;
  logic [18:0] out2;
  logic        vld2;
`ifdef CLT_DROP_COUNT_EN
  logic [15:0] drop_count;
  logic [15:0] drop_count2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clt_gaussian_acc #(.UW(8), .LOG2_N(2)) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .urgn_seed   (urgn_seed),
    .urgn_valid  (urgn_valid),
    .noise_out   (noise_out),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready)
`ifdef CLT_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  clt_gaussian_acc u_dut_def (
    .clk         (clk),
    .resetn      (resetn),
    .urgn_seed   (seed2),
    .urgn_valid  (valid2),
    .noise_out   (out2),
    .noise_valid (vld2),
    .noise_ready (1'b1)
`ifdef CLT_DROP_COUNT_EN
    ,
    .drop_count  (drop_count2)
`endif
  );

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [9:0]      exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    urgn_seed  = {b, 24'hA5C35A};
    urgn_valid = 1'b1;
    tick();
    urgn_valid = 1'b0;
    urgn_seed  = 32'hDEADBEEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0].s = {8'h80, 8'h80, 8'h80, 8'h80}; vecs[0].exp = 10'h000;
    vecs[1].s = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].exp = 10'h1FC;
    vecs[2].s = {8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].exp = 10'h200;
    vecs[3].s = {8'h04, 8'h03, 8'h02, 8'h01}; vecs[3].exp = 10'h20A;
    vecs[4].s = {8'h80, 8'h7F, 8'h81, 8'h80}; vecs[4].exp = 10'h000;
    vecs[5].s = {8'h40, 8'h30, 8'h20, 8'h10}; vecs[5].exp = 10'h2A0;

    resetn      = 1'b0;
    urgn_valid  = 1'b1;
    urgn_seed   = 32'hFFFFFFFF;
    noise_ready = 1'b1;
    seed2       = 32'h0;
    valid2      = 1'b0;
    tick();
    tick();
    check("reset_valid", {31'd0, noise_valid}, 32'd0);
    check("reset_out", {22'd0, noise_out}, 32'd0);
`ifdef CLT_DROP_COUNT_EN
    check("reset_drops", {16'd0, drop_count}, 32'd0);
`endif
    urgn_valid = 1'b0;
    resetn     = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        send(vecs[i].s[k]);
        if (k < 3) check($sformatf("vec%0d_early_valid", i), {31'd0, noise_valid}, 32'd0);
      end
      check($sformatf("vec%0d_valid", i), {31'd0, noise_valid}, 32'd1);
      check($sformatf("vec%0d_out", i), {22'd0, noise_out}, {22'd0, vecs[i].exp});
      tick();
      check($sformatf("vec%0d_accept", i), {31'd0, noise_valid}, 32'd0);
    end

    // Gaps between samples must not advance the count.
    for (int k = 1; k <= 4; k++) begin
      send(8'(k));
      if (k < 4) begin
        repeat (3) tick();
        check($sformatf("gap%0d_valid", k), {31'd0, noise_valid}, 32'd0);
      end
    end
    check("gap_valid", {31'd0, noise_valid}, 32'd1);
    check("gap_out", {22'd0, noise_out}, 32'h20A);
    tick();

    // Back-to-back stream with ready high: one output per 4 samples.
    for (int k = 0; k < 8; k++) begin
      send(8'hFF);
      if (k == 3 || k == 7) begin
        check($sformatf("stream%0d_valid", k), {31'd0, noise_valid}, 32'd1);
        check($sformatf("stream%0d_out", k), {22'd0, noise_out}, 32'h1FC);
      end else begin
        check($sformatf("stream%0d_valid", k), {31'd0, noise_valid}, 32'd0);
      end
    end
    tick();
`ifdef CLT_DROP_COUNT_EN
    check("stream_drops", {16'd0, drop_count}, 32'd0);
`endif

    // Backpressure: second result parks in HOLD, later samples dropped.
    noise_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      send(8'h80);
      if (k == 3 || k == 7 || k == 11) begin
        check($sformatf("bp%0d_valid", k), {31'd0, noise_valid}, 32'd1);
        check($sformatf("bp%0d_out", k), {22'd0, noise_out}, 32'h000);
      end
    end
`ifdef CLT_DROP_COUNT_EN
    check("bp_drops", {16'd0, drop_count}, 32'd4);
`endif
    noise_ready = 1'b1;
    tick();
    check("bp_reload_valid", {31'd0, noise_valid}, 32'd1);
    check("bp_reload_out", {22'd0, noise_out}, 32'h000);
    tick();
    check("bp_drain_valid", {31'd0, noise_valid}, 32'd0);
    for (int k = 0; k < 4; k++) send(8'h00);
    check("bp_restart_valid", {31'd0, noise_valid}, 32'd1);
    check("bp_restart_out", {22'd0, noise_out}, 32'h200);
    tick();
`ifdef CLT_DROP_COUNT_EN
    check("bp_drops_kept", {16'd0, drop_count}, 32'd4);
`endif

    // Reset after a partial sum discards it.
    send(8'hFF);
    send(8'hFF);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(8'hFF);
      if (k < 3) check($sformatf("rst_partial%0d_valid", k), {31'd0, noise_valid}, 32'd0);
    end
    check("rst_partial_valid", {31'd0, noise_valid}, 32'd1);
    check("rst_partial_out", {22'd0, noise_out}, 32'h1FC);

    // Reset discards a held result.
    noise_ready = 1'b0;
    tick();
    check("held_before_rst", {31'd0, noise_valid}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("held_after_rst_valid", {31'd0, noise_valid}, 32'd0);
    check("held_after_rst_out", {22'd0, noise_out}, 32'd0);
    noise_ready = 1'b1;
    tick();

    // Default parameters: 8 x 16'hFFFF.
    for (int k = 0; k < 8; k++) begin
      seed2  = 32'hFFFF1234;
      valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      if (k < 7) check($sformatf("def%0d_valid", k), {31'd0, vld2}, 32'd0);
    end
    check("def_valid", {31'd0, vld2}, 32'd1);
    check("def_out", {13'd0, out2}, 32'h3FFF8);
    tick();
    check("def_accept", {31'd0, vld2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
